// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path: segment bit positions,
// the blank pattern and the active-low glyph table for all sixteen codes.
package seven_seg_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef logic [SEG_A:SEG_G] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Active-low glyphs, bit order a..g; entries 10..15 are the hex letters.
  localparam seg_t SEG_CODES [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic seg_t seg_lookup(input logic [3:0] code, input logic hex_en);
    seg_t res;
    res = SEG_CODES[code];
    if (!hex_en && (code > 4'd9)) res = SEG_BLANK;
    return res;
  endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Combinational 4-bit code to active-low segment decoder; with hex_en low the
// codes above 9 render as a blank digit.
module seven_seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_hex_en,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = seg_lookup(i_code, i_hex_en);
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// input latching, leading-zero/per-digit blanking and an anode guard interval.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16,
  parameter int HEX_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0] PRESC_TC  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_END = PW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic                    r_load_pending;
  logic                    r_frame_tick;
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic                    r_sh_lz;
  logic [6:0]              r_seg_p1;
  logic                    r_dp_p1;
  logic [NUM_DIGITS-1:0]   r_an_p1;

  logic                    w_presc_tc;
  logic                    w_idx_wrap;
  logic                    w_load;
  logic [NUM_DIGITS-1:0]   w_lz_kill;
  logic                    w_zero_run;
  logic [NUM_DIGITS-1:0]   w_kill;
  logic [3:0]              w_cur_code;
  logic                    w_cur_blank;
  logic                    w_cur_dp;
  logic                    w_in_guard;
  logic                    w_show;
  logic [6:0]              w_dec_seg;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;

  assign w_presc_tc = (r_presc == PRESC_TC);
  assign w_idx_wrap = w_presc_tc && (r_idx == IDX_LAST);
  assign w_load     = w_idx_wrap || r_load_pending;

  // Stage p0: free-running slot prescaler and digit index, independent of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      if (w_presc_tc) begin
        r_presc <= '0;
        r_idx   <= w_idx_wrap ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Frame latch: inputs are sampled only at the frame boundary so a digit
  // update from the time-keeping core never tears across a scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_pending <= 1'b1;
      r_frame_tick   <= 1'b0;
      r_sh_digits    <= '0;
      r_sh_dp        <= '0;
      r_sh_blank     <= '1;
      r_sh_lz        <= 1'b0;
    end else begin
      r_load_pending <= 1'b0;
      r_frame_tick   <= w_load;
      if (w_load) begin
        r_sh_digits <= digits_in;
        r_sh_dp     <= dp_in;
        r_sh_blank  <= blank_mask;
        r_sh_lz     <= lz_blank;
      end
    end
  end

  // A digit is a leading zero when it and every more-significant code are zero.
  always_comb begin
    w_lz_kill  = '0;
    w_zero_run = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      w_zero_run = 1'b1;
      for (int j = i; j < NUM_DIGITS; j++) begin
        if (r_sh_digits[4*j +: 4] != 4'd0) w_zero_run = 1'b0;
      end
      w_lz_kill[i] = r_sh_lz && w_zero_run;
    end
  end

  assign w_kill      = r_sh_blank | w_lz_kill;
  assign w_cur_code  = r_sh_digits[{r_idx, 2'b00} +: 4];
  assign w_cur_blank = w_kill[r_idx];
  assign w_cur_dp    = r_sh_dp[r_idx];
  assign w_in_guard  = (r_presc < GUARD_END);
  assign w_show      = enable && !w_in_guard;

  seven_seg_hex_decoder u_dec (
    .i_code   (w_cur_code),
    .i_hex_en (HEX_MODE != 0),
    .o_seg    (w_dec_seg)
  );

  always_comb begin
    w_an_nxt = '1;
    if (w_show) w_an_nxt[r_idx] = 1'b0;
    w_seg_nxt = (w_show && !w_cur_blank) ? w_dec_seg : SEG_BLANK;
    w_dp_nxt  = !(w_show && !w_cur_blank && w_cur_dp);
  end

  // Stage p1: registered pin drivers; reset blanks the display asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_p1 <= SEG_BLANK;
      r_dp_p1  <= 1'b1;
      r_an_p1  <= '1;
    end else begin
      r_seg_p1 <= w_seg_nxt;
      r_dp_p1  <= w_dp_nxt;
      r_an_p1  <= w_an_nxt;
    end
  end

  assign seg        = r_seg_p1;
  assign dp         = r_dp_p1;
  assign an         = r_an_p1;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: NUM_DIGITS=4, REFRESH_DIV=8,
// GUARD_CYCLES=2, with one decimal-only and one hex-mode instance.
module tb_seven_seg_scan_driver;

  localparam logic [6:0] BL = 7'b1111111;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lz_blank;
  logic [6:0]  seg, seg_h;
  logic        dp, dp_h;
  logic [3:0]  an, an_h;
  logic        tick, tick_h;

  int total;
  int bad;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2), .HEX_MODE(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in),
    .dp_in(dp_in), .blank_mask(blank_mask), .lz_blank(lz_blank),
    .seg(seg), .dp(dp), .an(an), .frame_tick(tick)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2), .HEX_MODE(1)
  ) u_dut_hex (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in),
    .dp_in(dp_in), .blank_mask(blank_mask), .lz_blank(lz_blank),
    .seg(seg_h), .dp(dp_h), .an(an_h), .frame_tick(tick_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, " an"}, 32'(an), 32'hF);
    chk({tag, " seg"}, 32'(seg), 32'(BL));
    chk({tag, " dp"}, 32'(dp), 32'h1);
    chk({tag, " tick"}, 32'(tick), 32'h0);
  endtask

  // Waits for the next frame_tick; returns at the negedge where it is high.
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 100);
    chk("frame_tick", 32'(tick), 32'h1);
    chk("frame_tick_hex", 32'(tick_h), 32'h1);
  endtask

  // j counts negedges after a frame_tick; outputs then show the slot state of
  // cycle j-1: prescaler (j-1)%8, digit (j-1)/8, lit from prescaler 2 onward.
  task automatic check_frame(input bit hx, input int j0, input logic [27:0] es,
                             input logic [3:0] edp, input int chg_j,
                             input logic [15:0] chg_v, input int eoff_j);
    int p, d;
    bit lit;
    logic [3:0] ean, gan;
    logic [6:0] eseg, gseg;
    logic edpo, gdp;
    for (int j = j0; j <= 31; j++) begin
      @(negedge clk);
      p = (j - 1) % 8;
      d = (j - 1) / 8;
      lit = (p >= 2) && !(eoff_j > 0 && j > eoff_j && j <= eoff_j + 5);
      ean  = lit ? ~(4'b0001 << d) : 4'hF;
      eseg = lit ? es[7*d +: 7] : BL;
      edpo = lit ? ~edp[d] : 1'b1;
      gan  = hx ? an_h : an;
      gseg = hx ? seg_h : seg;
      gdp  = hx ? dp_h : dp;
      chk($sformatf("an j=%0d", j), 32'(gan), 32'(ean));
      chk($sformatf("seg j=%0d", j), 32'(gseg), 32'(eseg));
      chk($sformatf("dp j=%0d", j), 32'(gdp), 32'(edpo));
      if (j == chg_j) digits_in = chg_v;
      if (eoff_j > 0 && j == eoff_j) enable = 1'b0;
      if (eoff_j > 0 && j == eoff_j + 5) enable = 1'b1;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    enable = 1'b1;
    digits_in = 16'h1234;
    dp_in = 4'b0000;
    blank_mask = 4'b0000;
    lz_blank = 1'b0;

    // Reset and basic scan of 1234
    repeat (3) begin
      @(negedge clk);
      chk_blank("reset");
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_tick", 32'(tick), 32'h1);
    chk("first_an", 32'(an), 32'hF);
    check_frame(1'b0, 2, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                4'b0000, 0, 16'h0, 0);

    // Tearing: change inputs while digit 2 is being scanned
    wait_tick();
    check_frame(1'b0, 1, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                4'b0000, 18, 16'h5678, 0);
    wait_tick();
    check_frame(1'b0, 1, {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000},
                4'b0000, 0, 16'h0, 0);

    // Leading-zero blanking
    digits_in = 16'h0040;
    lz_blank = 1'b1;
    wait_tick();
    check_frame(1'b0, 1, {BL, BL, 7'b1001100, 7'b0000001}, 4'b0000, 0, 16'h0, 0);
    digits_in = 16'h0000;
    wait_tick();
    check_frame(1'b0, 1, {BL, BL, BL, 7'b0000001}, 4'b0000, 0, 16'h0, 0);

    // Hex glyphs and decimal point, then the same codes in decimal mode
    lz_blank = 1'b0;
    digits_in = 16'hABCD;
    dp_in = 4'b0100;
    wait_tick();
    check_frame(1'b1, 1, {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010},
                4'b0100, 0, 16'h0, 0);
    wait_tick();
    check_frame(1'b0, 1, {BL, BL, BL, BL}, 4'b0100, 0, 16'h0, 0);

    // Blank mask overrides dp; enable dropped for 5 cycles mid-frame
    digits_in = 16'h1234;
    dp_in = 4'b0011;
    blank_mask = 4'b0010;
    wait_tick();
    check_frame(1'b0, 1, {7'b1001111, 7'b0010010, BL, 7'b1001100},
                4'b0001, 0, 16'h0, 18);

    // Reset at digit 3, prescaler 5
    wait_tick();
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_blank("midreset");
    repeat (2) @(negedge clk);
    chk_blank("midreset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_tick", 32'(tick), 32'h1);
    check_frame(1'b0, 2, {7'b1001111, 7'b0010010, BL, 7'b1001100},
                4'b0001, 0, 16'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
